// File: rtl/sifive_reset_request.sv
// sifive_reset_request: merges power-on, button, PLL lock and software resets into a sequenced reset_out.
module sifive_reset_request #(
  parameter int SYNC_STAGES   = 4,
  parameter int PULSE_BITS    = 8,
  parameter int LOCK_BITS     = 6,
  parameter int DEBOUNCE_BITS = 8
) (
  input  logic       clock,
  input  logic       areset,
  input  logic       button,
  input  logic       pll_locked,
  input  logic       sw_req,
  input  logic       cause_clear,
  output logic       pll_reset,
  output logic       reset_out,
  output logic [3:0] cause
);
  localparam int CW = PULSE_BITS > LOCK_BITS ? PULSE_BITS : LOCK_BITS;
  localparam logic [CW-1:0] PULSE_MAX = CW'((64'd1 << PULSE_BITS) - 64'd1);
  localparam logic [CW-1:0] LOCK_MAX = CW'((64'd1 << LOCK_BITS) - 64'd1);
  typedef enum logic [1:0] {PLL_RST, SOFT_RST, WAIT_LOCK, RUN} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] btn_sync, lock_sync;
  logic [DEBOUNCE_BITS-1:0] db_cnt;
  logic [CW-1:0] cnt;
  logic btn_db, btn_db_d, btn_s, lock_s, btn_evt;
  logic [3:0] cause_set;
  assign btn_s = btn_sync[SYNC_STAGES-1];
  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign btn_evt = btn_db & ~btn_db_d;
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      btn_sync <= '0;
      lock_sync <= '0;
      db_cnt <= '0;
      btn_db <= 1'b0;
      btn_db_d <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], button};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
      btn_db_d <= btn_db;
      if (btn_s == btn_db) db_cnt <= '0;
      else if (db_cnt == '1) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + DEBOUNCE_BITS'(1);
    end
  end
  // Only RUN records causes, and only the highest-priority event of the cycle.
  always_comb begin
    cause_set = 4'b0000;
    if (state == RUN) cause_set = btn_evt ? 4'b0010 : !lock_s ? 4'b1000 : sw_req ? 4'b0100 : 4'b0000;
  end
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      state <= PLL_RST;
      cnt <= '0;
      pll_reset <= 1'b1;
      reset_out <= 1'b1;
      cause <= 4'b0001;
    end else begin
      cause <= (cause_clear ? 4'b0000 : cause) | cause_set;
      case (state)
        PLL_RST: begin
          if (btn_db) cnt <= '0;
          else if (cnt == PULSE_MAX) begin
            state <= WAIT_LOCK;
            cnt <= '0;
            pll_reset <= 1'b0;
          end else cnt <= cnt + CW'(1);
        end
        SOFT_RST: begin
          if (btn_evt) begin
            state <= PLL_RST;
            cnt <= '0;
            pll_reset <= 1'b1;
          end else if (cnt == PULSE_MAX) begin
            state <= WAIT_LOCK;
            cnt <= '0;
          end else cnt <= cnt + CW'(1);
        end
        WAIT_LOCK: begin
          if (btn_evt) begin
            state <= PLL_RST;
            cnt <= '0;
            pll_reset <= 1'b1;
          end else if (!lock_s) cnt <= '0;
          else if (cnt == LOCK_MAX) begin
            state <= RUN;
            cnt <= '0;
            reset_out <= 1'b0;
          end else cnt <= cnt + CW'(1);
        end
        RUN: begin
          cnt <= '0;
          if (btn_evt) begin
            state <= PLL_RST;
            pll_reset <= 1'b1;
            reset_out <= 1'b1;
          end else if (!lock_s) begin
            state <= WAIT_LOCK;
            reset_out <= 1'b1;
          end else if (sw_req) begin
            state <= SOFT_RST;
            reset_out <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sifive_reset_request.sv
// tb_sifive_reset_request: directed scenario checks of reset sequencing, debounce and cause bits.
module tb_sifive_reset_request;
  logic clock = 1'b0;
  logic areset = 1'b1;
  logic button = 1'b0;
  logic pll_locked = 1'b1;
  logic sw_req = 1'b0;
  logic cause_clear = 1'b0;
  logic pll_reset, reset_out;
  logic [3:0] cause;
  int compared = 0;
  int mismatched = 0;
  sifive_reset_request #(.SYNC_STAGES(2), .PULSE_BITS(4), .LOCK_BITS(3), .DEBOUNCE_BITS(3)) dut (
    .clock(clock), .areset(areset), .button(button), .pll_locked(pll_locked), .sw_req(sw_req),
    .cause_clear(cause_clear), .pll_reset(pll_reset), .reset_out(reset_out), .cause(cause)
  );
  always #5 clock = ~clock;
  task automatic test_reset;
    repeat (5) @(posedge clock);
    #1;
    compared++;
    if ({pll_reset, reset_out, cause} !== 6'b11_0001) begin
      mismatched++;
      $display("FAIL reset_values: got %b expected 110001", {pll_reset, reset_out, cause});
    end
  endtask
  task automatic test_power_on;
    int n;
    areset = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1; n++;
      if (!pll_reset) break;
    end
    compared++;
    if (n !== 16) begin
      mismatched++;
      $display("FAIL power_on_pll_pulse: got %0d edges expected 16", n);
    end
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1; n++;
      if (!reset_out) break;
    end
    compared++;
    if (n !== 8) begin
      mismatched++;
      $display("FAIL power_on_lock_wait: got %0d edges expected 8", n);
    end
    compared++;
    if (cause !== 4'b0001) begin
      mismatched++;
      $display("FAIL power_on_cause: got %b expected 0001", cause);
    end
  endtask
  task automatic test_lock_glitch;
    int n;
    @(posedge clock); #1 areset = 1'b1;
    @(posedge clock); #1 areset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (!pll_reset) break;
    end
    repeat (5) @(posedge clock);
    #1 pll_locked = 1'b0;
    @(posedge clock); #1 pll_locked = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1; n++;
      if (!reset_out) break;
    end
    compared++;
    if (n !== 10) begin
      mismatched++;
      $display("FAIL lock_glitch_restart: got %0d edges expected 10", n);
    end
  endtask
  task automatic test_button;
    int n, rises;
    logic prev;
    #0 button = 1'b1;
    repeat (2) @(posedge clock);
    #1 button = 1'b0;
    repeat (2) @(posedge clock);
    #1 button = 1'b1;
    compared++;
    if (reset_out !== 1'b0) begin
      mismatched++;
      $display("FAIL button_bounce_ignored: reset_out got %b expected 0", reset_out);
    end
    rises = 0;
    prev = pll_reset;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (pll_reset && !prev) rises++;
      prev = pll_reset;
    end
    compared++;
    if (rises !== 1) begin
      mismatched++;
      $display("FAIL button_single_entry: got %0d entries expected 1", rises);
    end
    compared++;
    if ({pll_reset, reset_out, cause} !== 6'b11_0011) begin
      mismatched++;
      $display("FAIL button_held: got %b expected 110011", {pll_reset, reset_out, cause});
    end
    button = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1; n++;
      if (!pll_reset) break;
    end
    compared++;
    if (n !== 26) begin
      mismatched++;
      $display("FAIL button_release_pulse: got %0d edges expected 26", n);
    end
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1; n++;
      if (!reset_out) break;
    end
    compared++;
    if (n !== 8) begin
      mismatched++;
      $display("FAIL button_relock: got %0d edges expected 8", n);
    end
  endtask
  task automatic test_soft_reset;
    int n;
    logic saw_pll;
    sw_req = 1'b1;
    @(posedge clock); #1 sw_req = 1'b0;
    compared++;
    if ({pll_reset, reset_out} !== 2'b01) begin
      mismatched++;
      $display("FAIL soft_entry: got %b expected 01", {pll_reset, reset_out});
    end
    n = 0;
    saw_pll = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1; n++;
      sw_req = (n == 3);
      if (pll_reset) saw_pll = 1'b1;
      if (!reset_out) break;
    end
    sw_req = 1'b0;
    compared++;
    if (n !== 24) begin
      mismatched++;
      $display("FAIL soft_duration: got %0d edges expected 24", n);
    end
    compared++;
    if (saw_pll !== 1'b0) begin
      mismatched++;
      $display("FAIL soft_pll_quiet: pll_reset seen %b expected 0", saw_pll);
    end
    compared++;
    if (cause !== 4'b0111) begin
      mismatched++;
      $display("FAIL soft_cause: got %b expected 0111", cause);
    end
  endtask
  task automatic test_lock_loss_clear;
    int n;
    pll_locked = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1; n++;
      if (reset_out) break;
    end
    compared++;
    if (n !== 3) begin
      mismatched++;
      $display("FAIL lock_loss_latency: got %0d edges expected 3", n);
    end
    compared++;
    if ({pll_reset, cause} !== 5'b0_1111) begin
      mismatched++;
      $display("FAIL lock_loss_cause: got %b expected 01111", {pll_reset, cause});
    end
    pll_locked = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1; n++;
      if (!reset_out) break;
    end
    compared++;
    if (n !== 10) begin
      mismatched++;
      $display("FAIL lock_regain: got %0d edges expected 10", n);
    end
    cause_clear = 1'b1;
    sw_req = 1'b1;
    @(posedge clock); #1 sw_req = 1'b0;
    compared++;
    if ({reset_out, cause} !== 5'b1_0100) begin
      mismatched++;
      $display("FAIL clear_with_set: got %b expected 10100", {reset_out, cause});
    end
    @(posedge clock); #1 cause_clear = 1'b0;
    compared++;
    if (cause !== 4'b0000) begin
      mismatched++;
      $display("FAIL clear_only: got %b expected 0000", cause);
    end
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (!reset_out) break;
    end
    compared++;
    if (reset_out !== 1'b0) begin
      mismatched++;
      $display("FAIL soft_recover: reset_out got %b expected 0", reset_out);
    end
  endtask
  task automatic test_simultaneous;
    button = 1'b1;
    repeat (10) @(posedge clock);
    #1 sw_req = 1'b1;
    compared++;
    if (pll_reset !== 1'b0) begin
      mismatched++;
      $display("FAIL simul_pre_event: pll_reset got %b expected 0", pll_reset);
    end
    @(posedge clock); #1 sw_req = 1'b0;
    compared++;
    if ({pll_reset, reset_out, cause} !== 6'b11_0010) begin
      mismatched++;
      $display("FAIL simul_btn_wins: got %b expected 110010", {pll_reset, reset_out, cause});
    end
    button = 1'b0;
  endtask
  task automatic test_mid_reset;
    int n;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (!pll_reset) break;
    end
    @(posedge clock);
    #3 areset = 1'b1;
    #1;
    compared++;
    if ({pll_reset, reset_out, cause} !== 6'b11_0001) begin
      mismatched++;
      $display("FAIL mid_areset: got %b expected 110001", {pll_reset, reset_out, cause});
    end
    repeat (2) @(posedge clock);
    #1 areset = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1; n++;
      if (!pll_reset) break;
    end
    compared++;
    if (n !== 16) begin
      mismatched++;
      $display("FAIL mid_areset_pulse: got %0d edges expected 16", n);
    end
  endtask
  initial begin
    test_reset();
    test_power_on();
    test_lock_glitch();
    test_button();
    test_soft_reset();
    test_lock_loss_clear();
    test_simultaneous();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
